// File: rtl/video_timing_gen_pkg.sv
// video_timing_pkg
// Shared timing constants for the video timing generator. Default timing is
// 640x480@60 (800x525 total). Also holds the colour-bar table and a helper
// that maps a horizontal position to its bar colour.
package video_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_CW       = 10;

    // Total period of one axis, including all blanking intervals.
    function automatic int axis_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

    // Bar colours as {r, g, b}, left to right across the active line.
    localparam logic [23:0] BAR_COLOURS [8] = '{
        24'hFFFFFF,   // white
        24'hFFFF00,   // yellow
        24'h00FFFF,   // cyan
        24'h00FF00,   // green
        24'hFF00FF,   // magenta
        24'hFF0000,   // red
        24'h0000FF,   // blue
        24'h000000    // black
    };

    // Bar index found by threshold compares so no divider is built.
    function automatic logic [23:0] bar_colour(input int xpos, input int bar_w);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (xpos >= i * bar_w) begin
                idx = 3'(i);
            end
        end
        return BAR_COLOURS[idx];
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// video_timing_gen_if
// Bundles the pixel-advance enable and every raster output of the timing
// generator.
//   master (generator): in en; out x, y, blanking, hsync, vsync,
//                       line_start, frame_start, pat_r, pat_g, pat_b
//   slave  (consumer) : the mirror image
interface video_timing_gen_if #(
    parameter int CW = video_timing_pkg::DEF_CW
);
    logic          en;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          blanking;
    logic          hsync;
    logic          vsync;
    logic          line_start;
    logic          frame_start;
    logic [7:0]    pat_r;
    logic [7:0]    pat_g;
    logic [7:0]    pat_b;

    modport master (
        input  en,
        output x, y, blanking, hsync, vsync, line_start, frame_start,
               pat_r, pat_g, pat_b
    );

    modport slave (
        output en,
        input  x, y, blanking, hsync, vsync, line_start, frame_start,
               pat_r, pat_g, pat_b
    );
endinterface

// File: rtl/video_timing_gen_sync_axis_counter.sv
// sync_axis_counter
// One raster axis: a wrapping position counter with a registered sync-window
// decode. The next count is exported so the parent can decode its own
// registered flags in step with the count.
//   clk, rst_n : pixel clock, async active-low reset
//   step       : advance by one position
//   count      : registered position
//   count_nx   : value count takes at the next edge
//   sync       : registered sync level for count (POL when inside window)
//   carry      : step while on the last position (wrap this edge)
module sync_axis_counter #(
    parameter int CW     = 10,
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter bit POL    = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          step,
    output logic [CW-1:0] count,
    output logic [CW-1:0] count_nx,
    output logic          sync,
    output logic          carry
);
    import video_timing_pkg::*;

    localparam int            TOTAL   = axis_total(ACTIVE, FP, SYNC, BP);
    localparam logic [CW-1:0] LAST    = CW'(TOTAL - 1);
    localparam logic [CW-1:0] SYNC_LO = CW'(ACTIVE + FP);
    localparam logic [CW-1:0] SYNC_HI = CW'(ACTIVE + FP + SYNC);

    // Compare with >= so any out-of-range value also wraps to zero.
    assign carry = step && (count >= LAST);

    always_comb begin
        count_nx = count;
        if (step) begin
            count_nx = (count >= LAST) ? '0 : count + 1'b1;
        end
    end

    // Sync is decoded from the next count so it lines up with count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            sync  <= !POL;
        end else if (step) begin
            count <= count_nx;
            sync  <= (count_nx >= SYNC_LO && count_nx < SYNC_HI) ? POL : !POL;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen
// Pixel-clock raster timing generator feeding the TMDS encoders. Produces
// the raster position, blanking, hsync/vsync and line/frame start markers,
// all registered and aligned with x/y in the same cycle.
//   clk, rst_n : pixel clock, async active-low reset
//   vif        : video_timing_gen_if.master (en in; x, y, blanking, hsync,
//                vsync, line_start, frame_start, pat_r/g/b out)
// Optional macro TEST_PATTERN_EN: drives an 8-bar colour pattern on
// pat_r/g/b; when undefined those outputs are constant zero.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CW        = DEF_CW
) (
    input  logic               clk,
    input  logic               rst_n,
    video_timing_gen_if.master vif
);
    localparam logic [CW-1:0] H_ACT = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT = CW'(V_ACTIVE);

    logic [CW-1:0] h_count, h_count_nx, v_count, v_count_nx;
    logic          h_sync, h_carry, v_sync, v_carry;
    logic          active_nx;
    logic          blanking_q, line_start_q, frame_start_q;

    sync_axis_counter #(
        .CW(CW), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP),
        .POL(HSYNC_POL)
    ) h_axis (
        .clk(clk), .rst_n(rst_n), .step(vif.en),
        .count(h_count), .count_nx(h_count_nx), .sync(h_sync), .carry(h_carry)
    );

    // The vertical axis advances only on the horizontal wrap.
    sync_axis_counter #(
        .CW(CW), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP),
        .POL(VSYNC_POL)
    ) v_axis (
        .clk(clk), .rst_n(rst_n), .step(h_carry),
        .count(v_count), .count_nx(v_count_nx), .sync(v_sync), .carry(v_carry)
    );

    assign active_nx = (h_count_nx < H_ACT) && (v_count_nx < V_ACT);

    // Flags decode from the next counts; a vertical carry is the only way
    // to land on (0,0), so it marks the coming frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blanking_q    <= 1'b0;
            line_start_q  <= 1'b1;
            frame_start_q <= 1'b1;
        end else if (vif.en) begin
            blanking_q    <= !active_nx;
            line_start_q  <= (h_count_nx == '0);
            frame_start_q <= v_carry;
        end
    end

    assign vif.x           = h_count;
    assign vif.y           = v_count;
    assign vif.hsync       = h_sync;
    assign vif.vsync       = v_sync;
    assign vif.blanking    = blanking_q;
    assign vif.line_start  = line_start_q;
    assign vif.frame_start = frame_start_q;

`ifdef TEST_PATTERN_EN
    logic [23:0] pat_q;

    // Pattern is black during blanking and zero out of reset until the
    // first advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q <= 24'h000000;
        end else if (vif.en) begin
            pat_q <= active_nx ? bar_colour(int'(h_count_nx), H_ACTIVE / 8) : 24'h000000;
        end
    end

    assign vif.pat_r = pat_q[23:16];
    assign vif.pat_g = pat_q[15:8];
    assign vif.pat_b = pat_q[7:0];
`else
    assign vif.pat_r = 8'h00;
    assign vif.pat_g = 8'h00;
    assign vif.pat_b = 8'h00;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen
// Drives two generator instances from a shared enable: dut0 with the default
// 640x480@60 timing (line-level behaviour) and dut1 with a small raster and
// active-high hsync so whole frames wrap quickly. Outputs are predicted from
// a pixel-count model and compared every cycle, with literal pins at the
// interesting raster positions.
module tb_video_timing_gen;

    localparam int S_HA = 64, S_HF = 4, S_HS = 8, S_HB = 4;
    localparam int S_VA = 24, S_VF = 2, S_VS = 2, S_VB = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b0;

    int tests = 0;
    int fails = 0;

    // Timing of each instance, indexed by dut number.
    int ha[2] = '{640, S_HA};
    int hf[2] = '{16,  S_HF};
    int hs[2] = '{96,  S_HS};
    int hb[2] = '{48,  S_HB};
    int va[2] = '{480, S_VA};
    int vf[2] = '{10,  S_VF};
    int vs[2] = '{2,   S_VS};
    int vb[2] = '{33,  S_VB};
    bit hp[2] = '{1'b0, 1'b1};
    bit vp[2] = '{1'b0, 1'b0};

    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    // Model: pixels advanced since reset, and whether no advance happened yet.
    int n[2]     = '{0, 0};
    bit fresh[2] = '{1'b1, 1'b1};

    video_timing_gen_if #(.CW(10)) if0 ();
    video_timing_gen_if #(.CW(10)) if1 ();
    assign if0.en = en;
    assign if1.en = en;

    video_timing_gen #(.CW(10)) dut0 (
        .clk(clk), .rst_n(rst_n), .vif(if0.master)
    );

    video_timing_gen #(
        .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .CW(10)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .vif(if1.master)
    );

    always #5 clk = ~clk;

    function automatic int htot(int k);
        return ha[k] + hf[k] + hs[k] + hb[k];
    endfunction

    function automatic int vtot(int k);
        return va[k] + vf[k] + vs[k] + vb[k];
    endfunction

    function automatic int mx(int k);
        return n[k] % htot(k);
    endfunction

    function automatic int my(int k);
        return (n[k] / htot(k)) % vtot(k);
    endfunction

    task automatic checkOutput(input string name, input int k,
                               input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL dut%0d.%s at t=%0t: got %0h, expected %0h",
                     k, name, $time, act, exp);
        end
    endtask

    task automatic compareAll(input int k);
        logic [9:0]  ax, ay;
        logic        ab, ahs, avs, als, afs;
        logic [23:0] ap;
        int          x, y;
        logic [23:0] ep;
        bit          eb;
        if (k == 0) begin
            ax = if0.x; ay = if0.y; ab = if0.blanking; ahs = if0.hsync;
            avs = if0.vsync; als = if0.line_start; afs = if0.frame_start;
            ap = {if0.pat_r, if0.pat_g, if0.pat_b};
        end else begin
            ax = if1.x; ay = if1.y; ab = if1.blanking; ahs = if1.hsync;
            avs = if1.vsync; als = if1.line_start; afs = if1.frame_start;
            ap = {if1.pat_r, if1.pat_g, if1.pat_b};
        end
        x  = mx(k);
        y  = my(k);
        eb = !(x < ha[k] && y < va[k]);
        ep = 24'h000000;
`ifdef TEST_PATTERN_EN
        if (!fresh[k] && !eb) ep = bars[3'(x / (ha[k] / 8))];
`endif
        checkOutput("x", k, 32'(ax), x);
        checkOutput("y", k, 32'(ay), y);
        checkOutput("blanking", k, 32'(ab), 32'(eb));
        checkOutput("hsync", k, 32'(ahs),
                    32'((x >= ha[k] + hf[k] && x < ha[k] + hf[k] + hs[k]) ? hp[k] : !hp[k]));
        checkOutput("vsync", k, 32'(avs),
                    32'((y >= va[k] + vf[k] && y < va[k] + vf[k] + vs[k]) ? vp[k] : !vp[k]));
        checkOutput("line_start", k, 32'(als), 32'(x == 0));
        checkOutput("frame_start", k, 32'(afs), 32'(x == 0 && y == 0));
        checkOutput("pattern", k, 32'(ap), 32'(ep));
    endtask

    // The model advances on every enabled clock outside reset; everything is
    // sampled 1 ns after the edge.
    always @(posedge clk) begin
        #1;
        if (rst_n && en) begin
            for (int k = 0; k < 2; k++) begin
                n[k]++;
                fresh[k] = 1'b0;
            end
        end
        compareAll(0);
        compareAll(1);
    end

    always @(negedge rst_n) begin
        n     = '{0, 0};
        fresh = '{1'b1, 1'b1};
    end

    // Literal expectations at raster positions worked out by hand.
    task automatic pinChecks();
        int x0, y0, x1, y1;
        x0 = mx(0); y0 = my(0); x1 = mx(1); y1 = my(1);
        if (!fresh[0]) begin
            if (y0 == 0 && x0 == 639) checkOutput("pin_blank_639", 0, 32'(if0.blanking), 0);
            if (y0 == 0 && x0 == 640) checkOutput("pin_blank_640", 0, 32'(if0.blanking), 1);
            if (x0 == 655) checkOutput("pin_hsync_655", 0, 32'(if0.hsync), 1);
            if (x0 == 656) checkOutput("pin_hsync_656", 0, 32'(if0.hsync), 0);
            if (x0 == 751) checkOutput("pin_hsync_751", 0, 32'(if0.hsync), 0);
            if (x0 == 752) checkOutput("pin_hsync_752", 0, 32'(if0.hsync), 1);
            if (x0 == 0 && y0 == 1) begin
                checkOutput("pin_wrap_y", 0, 32'(if0.y), 1);
                checkOutput("pin_wrap_ls", 0, 32'(if0.line_start), 1);
            end
`ifdef TEST_PATTERN_EN
            if (x0 == 0 && y0 < 480)
                checkOutput("pin_pat_0", 0, 32'({if0.pat_r, if0.pat_g, if0.pat_b}), 32'h00FFFFFF);
            if (x0 == 80 && y0 < 480)
                checkOutput("pin_pat_80", 0, 32'({if0.pat_r, if0.pat_g, if0.pat_b}), 32'h00FFFF00);
            if (x0 == 639)
                checkOutput("pin_pat_639", 0, 32'({if0.pat_r, if0.pat_g, if0.pat_b}), 0);
            if (x0 == 700)
                checkOutput("pin_pat_700", 0, 32'({if0.pat_r, if0.pat_g, if0.pat_b}), 0);
`else
            if (x0 == 80)
                checkOutput("pin_pat_off", 0, 32'({if0.pat_r, if0.pat_g, if0.pat_b}), 0);
`endif
        end
        if (!fresh[1]) begin
            if (y1 == 25) checkOutput("pin_vsync_25", 1, 32'(if1.vsync), 1);
            if (y1 == 26) checkOutput("pin_vsync_26", 1, 32'(if1.vsync), 0);
            if (y1 == 27) checkOutput("pin_vsync_27", 1, 32'(if1.vsync), 0);
            if (y1 == 28) checkOutput("pin_vsync_28", 1, 32'(if1.vsync), 1);
            if (y1 >= 24) checkOutput("pin_vblank", 1, 32'(if1.blanking), 1);
            if (x1 == 68) checkOutput("pin_hsync_68", 1, 32'(if1.hsync), 1);
            if (x1 == 76) checkOutput("pin_hsync_76", 1, 32'(if1.hsync), 0);
            if (x1 == 0 && y1 == 0) checkOutput("pin_frame_wrap", 1, 32'(if1.frame_start), 1);
            if (x1 == 1 && y1 == 0) checkOutput("pin_frame_drop", 1, 32'(if1.frame_start), 0);
        end
    endtask

    // Holds en at the given level for a number of cycles, pinning each one.
    task automatic applyStimulus(input bit e_val, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            en = e_val;
            @(negedge clk);
            pinChecks();
        end
    endtask

    task automatic runToX(input int target, input int limit);
        int guard;
        guard = 0;
        en = 1'b1;
        while (mx(0) != target && guard < limit) begin
            @(negedge clk);
            pinChecks();
            guard++;
        end
        if (mx(0) != target) begin
            tests++;
            fails++;
            $display("[TB] FAIL wait_x%0d: no arrival within %0d cycles, got %0d", target, limit, mx(0));
        end
    endtask

    task automatic pinReset(input int k);
        logic [9:0] ax, ay;
        logic [7:0] bits;
        if (k == 0) begin
            ax = if0.x; ay = if0.y;
            bits = {if0.blanking, if0.hsync, if0.vsync, if0.line_start, if0.frame_start,
                    |{if0.pat_r, if0.pat_g, if0.pat_b}, 2'b00};
        end else begin
            ax = if1.x; ay = if1.y;
            bits = {if1.blanking, if1.hsync, if1.vsync, if1.line_start, if1.frame_start,
                    |{if1.pat_r, if1.pat_g, if1.pat_b}, 2'b00};
        end
        checkOutput("rst_x", k, 32'(ax), 0);
        checkOutput("rst_y", k, 32'(ay), 0);
        // blanking, hsync, vsync, line_start, frame_start, any pattern bit
        checkOutput("rst_flags", k, 32'(bits), (k == 0) ? 32'h78 : 32'h38);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        pinReset(0);
        pinReset(1);

        rst_n = 1'b1;
        en    = 1'b1;
        @(negedge clk);
        checkOutput("first_x", 0, 32'(if0.x), 1);
        checkOutput("first_y", 0, 32'(if0.y), 0);
        checkOutput("first_blank", 0, 32'(if0.blanking), 0);
        checkOutput("first_hsync", 0, 32'(if0.hsync), 1);
        checkOutput("first_vsync", 0, 32'(if0.vsync), 1);
        checkOutput("first_ls", 0, 32'(if0.line_start), 0);
        checkOutput("first_fs", 0, 32'(if0.frame_start), 0);
        checkOutput("first_hsync", 1, 32'(if1.hsync), 0);

        runToX(300, 2000);
        for (int i = 0; i < 5; i++) begin
            en = 1'b0;
            @(negedge clk);
            checkOutput("hold_x", 0, 32'(if0.x), 300);
        end
        en = 1'b1;
        @(negedge clk);
        checkOutput("resume_x", 0, 32'(if0.x), 301);

        for (int i = 0; i < 6000; i++) begin
            applyStimulus($urandom_range(0, 7) != 0, 1);
        end

        runToX(400, 2000);
        #2;
        rst_n = 1'b0;
        #1;
        pinReset(0);
        pinReset(1);
        applyStimulus(1'b1, 2);
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
